// File: rtl/test_pattern_sequencer_if.sv
// Control/status bundle between a video timing/requester block and the test
// pattern sequencer: frame sync, operator inputs, load handshake and mux outputs.
interface test_pattern_sequencer_if;
    logic       v_sync;
    logic       button;
    logic       auto_enable;
    logic       select_valid;
    logic [2:0] select_data;
    logic       select_ready;
    logic [2:0] pattern_select;
    logic       blank_video;
    logic       pattern_change;

    modport master (
        output v_sync, button, auto_enable, select_valid, select_data,
        input  select_ready, pattern_select, blank_video, pattern_change
    );

    modport slave (
        input  v_sync, button, auto_enable, select_valid, select_data,
        output select_ready, pattern_select, blank_video, pattern_change
    );
endinterface

// File: rtl/test_pattern_sequencer.sv
// Test pattern sequencer: selects a video test pattern by load, debounced button
// or auto dwell timer, switching only on frame boundaries with blanked frames.
module test_pattern_sequencer #(
    parameter int NUM_PATTERNS    = 4,
    parameter int DWELL_FRAMES    = 300,
    parameter int BLANK_FRAMES    = 1,
    parameter int DEBOUNCE_CYCLES = 65535
) (
    input logic                     clk,
    input logic                     rst_n,
    test_pattern_sequencer_if.slave bus
);
    typedef enum logic [1:0] {SHOW, ARMED, BLANK} state_t;

    state_t      state, state_next;
    logic        v_sync_p1;
    logic        vs_edge;
    logic        btn_p0, btn_p1;
    logic [15:0] deb_cnt, deb_cnt_next;
    logic        deb_level, deb_level_next;
    logic        btn_req, btn_req_next;
    logic        auto_req;
    logic [9:0]  frame_cnt, frame_cnt_next;
    logic [3:0]  blank_cnt, blank_cnt_next;
    logic [2:0]  target, target_next;
    logic [2:0]  pattern, pattern_next;
    logic        blank, blank_next;
    logic        change, change_next;

    function automatic logic [9:0] sat_inc10(input logic [9:0] x);
        return (x == 10'h3FF) ? x : x + 10'd1;
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] x);
        return (x == 3'(NUM_PATTERNS - 1)) ? 3'd0 : x + 3'd1;
    endfunction

    function automatic logic [2:0] clamp_idx(input logic [2:0] x);
        return (int'(x) >= NUM_PATTERNS) ? 3'd0 : x;
    endfunction

    assign vs_edge = bus.v_sync && !v_sync_p1;

    always_comb begin
        state_next     = state;
        target_next    = target;
        pattern_next   = pattern;
        blank_next     = blank;
        change_next    = 1'b0;
        frame_cnt_next = frame_cnt;
        blank_cnt_next = blank_cnt;
        auto_req       = 1'b0;
        deb_level_next = deb_level;
        deb_cnt_next   = 16'd0;
        btn_req_next   = 1'b0;

        // Debounce: level follows the synced button only after a full run of disagreement
        if (btn_p1 != deb_level) begin
            if (deb_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                deb_level_next = btn_p1;
                btn_req_next   = btn_p1;
            end else begin
                deb_cnt_next = deb_cnt + 16'd1;
            end
        end

        unique case (state)
            SHOW: begin
                auto_req = bus.auto_enable && vs_edge &&
                           (frame_cnt == 10'(DWELL_FRAMES - 1));
                if (vs_edge && bus.auto_enable)
                    frame_cnt_next = sat_inc10(frame_cnt);
                if (bus.select_valid) begin
                    target_next = clamp_idx(bus.select_data);
                    state_next  = ARMED;
                end else if (btn_req || auto_req) begin
                    target_next = wrap_inc(pattern);
                    state_next  = ARMED;
                end
            end
            ARMED: begin
                if (vs_edge) begin
                    state_next     = BLANK;
                    pattern_next   = target;
                    blank_next     = 1'b1;
                    change_next    = 1'b1;
                    blank_cnt_next = 4'd0;
                end
            end
            BLANK: begin
                if (vs_edge) begin
                    if (blank_cnt == 4'(BLANK_FRAMES - 1)) begin
                        state_next     = SHOW;
                        blank_next     = 1'b0;
                        frame_cnt_next = 10'd0;
                    end else begin
                        blank_cnt_next = blank_cnt + 4'd1;
                    end
                end
            end
            default: state_next = SHOW;
        endcase
    end

    // Stage p0/p1: input synchronizers and all control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SHOW;
            v_sync_p1 <= 1'b0;
            btn_p0    <= 1'b0;
            btn_p1    <= 1'b0;
            deb_cnt   <= 16'd0;
            deb_level <= 1'b0;
            btn_req   <= 1'b0;
            frame_cnt <= 10'd0;
            blank_cnt <= 4'd0;
            pattern   <= 3'd0;
            blank     <= 1'b0;
            change    <= 1'b0;
        end else begin
            state     <= state_next;
            v_sync_p1 <= bus.v_sync;
            btn_p0    <= bus.button;
            btn_p1    <= btn_p0;
            deb_cnt   <= deb_cnt_next;
            deb_level <= deb_level_next;
            btn_req   <= btn_req_next;
            frame_cnt <= frame_cnt_next;
            blank_cnt <= blank_cnt_next;
            pattern   <= pattern_next;
            blank     <= blank_next;
            change    <= change_next;
        end
    end

    // Pending target is only meaningful in ARMED, so it carries no reset
    always_ff @(posedge clk) begin
        target <= target_next;
    end

    assign bus.select_ready   = (state == SHOW);
    assign bus.pattern_select = pattern;
    assign bus.blank_video    = blank;
    assign bus.pattern_change = change;
endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Randomized bench for test_pattern_sequencer, checked cycle by cycle against a
// frame/event-level reference model of the sequencing rules.
module tb_test_pattern_sequencer;
    localparam int NP   = 4;
    localparam int DW   = 3;
    localparam int BF   = 2;
    localparam int DB   = 20;
    localparam int NCYC = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    test_pattern_sequencer_if sif ();

    test_pattern_sequencer #(
        .NUM_PATTERNS   (NP),
        .DWELL_FRAMES   (DW),
        .BLANK_FRAMES   (BF),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = showing, 1 = waiting for frame, 2 = blanking
    int m_phase, m_pat, m_tgt, m_frames, m_bseen, m_run;
    bit m_blank, m_chg, m_vsq, m_meta, m_sync, m_deb, m_breq, m_acc;

    int vs_cnt = 5, vs_period = 12, btn_left = 30, nres = 0;
    bit btn_lvl = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pat = 0; m_tgt = 0; m_frames = 0; m_bseen = 0; m_run = 0;
        m_blank = 0; m_chg = 0; m_vsq = 0; m_meta = 0; m_sync = 0; m_deb = 0;
        m_breq = 0; m_acc = 0;
    endtask

    // Advance the model across one rising clock edge using the inputs now applied
    task automatic model_step();
        bit frame_start, auto_due, new_breq;
        frame_start = sif.v_sync && !m_vsq;
        m_acc = 0;
        m_chg = 0;
        case (m_phase)
            0: begin
                auto_due = sif.auto_enable && frame_start && (m_frames == DW - 1);
                if (frame_start && sif.auto_enable && m_frames < 1023) m_frames++;
                if (sif.select_valid) begin
                    m_tgt   = (int'(sif.select_data) >= NP) ? 0 : int'(sif.select_data);
                    m_phase = 1;
                    m_acc   = 1;
                end else if (m_breq || auto_due) begin
                    m_tgt   = (m_pat + 1) % NP;
                    m_phase = 1;
                end
            end
            1: begin
                if (frame_start) begin
                    m_pat   = m_tgt;
                    m_blank = 1;
                    m_chg   = 1;
                    m_bseen = 0;
                    m_phase = 2;
                end
            end
            default: begin
                if (frame_start) begin
                    m_bseen++;
                    if (m_bseen == BF) begin
                        m_phase  = 0;
                        m_blank  = 0;
                        m_frames = 0;
                    end
                end
            end
        endcase
        new_breq = 0;
        if (m_sync != m_deb) begin
            m_run++;
            if (m_run == DB) begin
                m_deb    = m_sync;
                new_breq = m_sync;
                m_run    = 0;
            end
        end else begin
            m_run = 0;
        end
        m_breq = new_breq;
        m_sync = m_meta;
        m_meta = sif.button;
        m_vsq  = sif.v_sync;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_ready"},   {31'd0, sif.select_ready},   (m_phase == 0) ? 32'd1 : 32'd0);
        chk({tag, "_pattern"}, {29'd0, sif.pattern_select}, 32'(m_pat));
        chk({tag, "_blank"},   {31'd0, sif.blank_video},    {31'd0, m_blank});
        chk({tag, "_change"},  {31'd0, sif.pattern_change}, {31'd0, m_chg});
    endtask

    task automatic gen_inputs();
        vs_cnt++;
        if (vs_cnt >= vs_period) begin
            vs_cnt    = 0;
            vs_period = int'($urandom_range(8, 20));
        end
        sif.v_sync = (vs_cnt < 2);
        btn_left--;
        if (btn_left <= 0) begin
            btn_lvl  = !btn_lvl;
            btn_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB - 2))
                                                   : int'($urandom_range(DB + 5, 4 * DB));
        end
        sif.button = btn_lvl;
        if ($urandom_range(0, 299) == 0) sif.auto_enable = !sif.auto_enable;
        if (m_acc) sif.select_valid = 1'b0;
        if (!sif.select_valid && $urandom_range(0, 79) == 0) begin
            sif.select_valid = 1'b1;
            sif.select_data  = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        sif.v_sync       = 1'b0;
        sif.button       = 1'b0;
        sif.auto_enable  = 1'b1;
        sif.select_valid = 1'b0;
        sif.select_data  = 3'd0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            gen_inputs();
            model_step();
            @(negedge clk);
            check_outputs("run");
            if (m_phase == 2 && nres < 4 && $urandom_range(0, 24) == 0) begin
                rst_n      = 1'b0;
                sif.v_sync = 1'b0;
                #1;
                chk("rst_ready",   {31'd0, sif.select_ready},   32'd1);
                chk("rst_pattern", {29'd0, sif.pattern_select}, 32'd0);
                chk("rst_blank",   {31'd0, sif.blank_video},    32'd0);
                chk("rst_change",  {31'd0, sif.pattern_change}, 32'd0);
                model_reset();
                repeat (2) @(negedge clk);
                check_outputs("rst_hold");
                rst_n  = 1'b1;
                vs_cnt = 2;
                nres++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/test_pattern_sequencer.md
TEST_PATTERN_SEQUENCER -- requirements
Module: TestPatternSequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 4, number of selectable patterns (2..8) SHALL be supported.
REQ-002 Parameter DWELL_FRAMES, default 300, frames per pattern in auto mode (1..1023) SHALL be supported.
REQ-003 Parameter BLANK_FRAMES, default 1, blanked frames inserted at each switch (1..15) SHALL be supported.
REQ-004 Parameter DEBOUNCE_CYCLES, default 65535, button stable time in clocks (1..65535) SHALL be supported.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 vSync  in  1  frame sync from timing generator, active high, synchronous to clock.
REQ-008 button  in  1  raw asynchronous push-button, active high.
REQ-009 autoEnable  in  1  1 = auto-advance after DWELL_FRAMES.
REQ-010 selectValid  in  1  direct pattern load request.
REQ-011 selectData  in  3  pattern index to load.
REQ-012 selectReady  out  1  load accepted when selectValid && selectReady.
REQ-013 patternSelect  out  3  current pattern index to datapath mux.
REQ-014 blankVideo  out  1  datapath SHALL force black while 1.
REQ-015 patternChange  out  1  one-cycle pulse on each patternSelect update.

Function
REQ-016 vSync edge: registered copy; edge = vSync && !vSyncQ; all frame events use this edge (1-cycle detect latency).
REQ-017 button: 2-flop synchronizer, then 16-bit counter; debounced level changes only after synced input differs from it for DEBOUNCE_CYCLES consecutive clocks; counter clears on any agreement.
REQ-018 Button request = rising edge of debounced level; one request per press; release generates nothing.
REQ-019 Frame counter (10 bit): clears on entering SHOW; increments on vSync edge in SHOW; auto request when autoEnable=1 and count reaches DWELL_FRAMES-1 on a vSync edge; saturates, no wrap.
REQ-020 States: SHOW, ARMED, BLANK.
REQ-021 SHOW: selectReady=1; accepts one request per cycle; priority load > button > auto; accepted request latches target index and moves to ARMED next cycle.
REQ-022 Targets: load -> selectData, replaced by 0 if >= NUM_PATTERNS; button/auto -> patternSelect+1, wrapping NUM_PATTERNS-1 -> 0.
REQ-023 ARMED: selectReady=0; on vSync edge -> BLANK; same cycle patternSelect <= target, blankVideo <= 1, patternChange pulses 1.
REQ-024 BLANK: selectReady=0; counts vSync edges; on edge number BLANK_FRAMES -> SHOW, blankVideo <= 0, frame counter cleared.
REQ-025 Button/auto requests in ARMED or BLANK SHALL be dropped; loads stall (selectValid held by requester).
REQ-026 Load target equal to current pattern still performs full ARMED/BLANK sequence.
REQ-027 vSync edge coincident with request acceptance in SHOW SHALL NOT advance ARMED; switch waits for next edge.
REQ-028 autoEnable deasserted mid-dwell: counter holds value, no auto request; reasserting resumes from held count.
REQ-029 All outputs registered; no combinational input-to-output path except none (selectReady derived from state register).

Reset
REQ-030 reset low: state=SHOW, patternSelect=0, blankVideo=0, patternChange=0, selectReady=1, frame counter=0, debounce counter=0, debounced level=0, vSyncQ=0, synchronizer flops=0.
REQ-031 reset asserted in ARMED or BLANK SHALL abandon the switch; pending target discarded.
REQ-032 First vSync after reset release counts as frame 1 only if it is a true rising edge.

Verification
REQ-033 Load 2 in SHOW, vSync edge 10 cycles later -> selectReady=0 next cycle; patternSelect=2, blankVideo=1, patternChange=1 for one cycle at the edge-detect cycle; blankVideo=0 one frame later.
REQ-034 NUM_PATTERNS=4, pattern 3, button held 65535 clocks -> single request, patternSelect wraps to 0; 100-clock glitch -> no request.
REQ-035 autoEnable=1, DWELL_FRAMES=3 -> pattern advances 0->1->2 every 3 SHOW frames plus BLANK_FRAMES.
REQ-036 selectValid, button press and auto expiry same cycle -> load target wins, others dropped, one patternChange.
REQ-037 selectData=6 with NUM_PATTERNS=4 -> patternSelect=0 after switch.
REQ-038 reset pulsed low in BLANK -> outputs immediately to REQ-030 values; next vSync does not change patternSelect.
